// File: rtl/ahb_ram_slave.sv
// AHB-Lite subordinate for the data-RAM region: word-organised memory with
// byte-lane writes, optional wait states and a two-cycle ERROR response.
module ahb_ram_slave #(
  parameter int unsigned MEM_AW      = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [7:0]  BASE        = 8'hB0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);
  localparam int unsigned DEPTH   = 2 ** MEM_AW;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned CNT_W   = 4;
  localparam logic [23:0] HI_MASK = 24'hFF_FFFF << (MEM_AW + 2);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  typedef struct packed {
    logic [MEM_AW-1:0] idx;
    logic [BE_W-1:0]   be;
    logic              write;
  } xfer_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  xfer_t              cur, cur_d, xfer_new;
  logic               hreadyout_d, hresp_d;
  logic [DATA_W-1:0]  hrdata_d, fwd_word, rd_word;
  logic               accept, addr_err, wr_fire;
  logic [BE_W-1:0]    be_new;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic               unused;

  assign unused  = htrans[0];
  assign accept  = hsel & hready & htrans[1] & (state inside {S_IDLE, S_DATA, S_ERR2});
  assign wr_fire = (state == S_DATA) & cur.write;

  // Address-phase decode: lane enables and error classification
  always_comb begin
    case (hsize[1:0])
      2'b00:   be_new = 4'b0001 << haddr[1:0];
      2'b01:   be_new = 4'b0011 << haddr[1:0];
      default: be_new = 4'b1111;
    endcase
    addr_err = (haddr[31:24] != BASE)
            || ((haddr[23:0] & HI_MASK) != 24'd0)
            || (hsize > 3'b010)
            || ((hsize == 3'b001) && haddr[0])
            || ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
    xfer_new.idx   = haddr[MEM_AW+1:2];
    xfer_new.be    = be_new;
    xfer_new.write = hwrite & ~addr_err;
  end

  // Word as it will look after the write completing on this edge
  always_comb begin
    fwd_word = mem[cur.idx];
    for (int b = 0; b < BE_W; b++) begin
      if (cur.be[b]) fwd_word[8*b +: 8] = hwdata[8*b +: 8];
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    cur_d       = cur;
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    hrdata_d    = '0;
    rd_word     = '0;

    case (state)
      S_WAIT: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_d = S_DATA;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          cur_d = xfer_new;
          cnt_d = CNT_W'(WAIT_STATES);
          if (addr_err)              state_d = S_ERR1;
          else if (WAIT_STATES == 0) state_d = S_DATA;
          else                       state_d = S_WAIT;
        end
      end
    endcase

    hreadyout_d = !(state_d inside {S_WAIT, S_ERR1});
    hresp_d     = state_d inside {S_ERR1, S_ERR2};

    // Same-edge write to the word being read is forwarded
    rd_word = (wr_fire && (cur_d.idx == cur.idx)) ? fwd_word : mem[cur_d.idx];
    if ((state_d == S_DATA) && !cur_d.write) hrdata_d = rd_word;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cur       <= '0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cur       <= cur_d;
      hreadyout <= hreadyout_d;
      hresp     <= hresp_d;
      hrdata    <= hrdata_d;
    end
  end

  // Memory is never cleared; a write pending under reset is dropped
  always_ff @(posedge hclk) begin
    if (!hreset && wr_fire) begin
      for (int b = 0; b < BE_W; b++) begin
        if (cur.be[b]) mem[cur.idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule
